// File: rtl/uart_mmio.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_mmio: memory-mapped 8N1 UART with DATA/STATUS registers             |
// | RX FIFO with overrun flag, one-byte TX holding register. Rev 1.0         |
// +--------------------------------------------------------------------------+
module uart_mmio #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        txd,
  input  logic        uart_en,
  input  logic        uart_we,
  input  logic        uart_addr,
  input  logic [7:0]  uart_wdata,
  output logic [31:0] uart_rdata,
  output logic        uart_overrun
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] c_div_m1  = CW'(DIV - 1);
  localparam logic [CW-1:0] c_half_m1 = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- RX ----------------
  logic            r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t       r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]   r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]      r_rx_bit, w_rx_bit_nxt;
  logic [7:0]      r_rx_shift, w_rx_shift_nxt;
  logic            w_rx_push;
  logic            w_rx_zero;

  assign w_rx_zero = (r_rx_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_meta  <= rxd;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_push      = 1'b0;
    unique case (r_rx_state)
      RX_IDLE: begin
        if (r_rx_prev && !r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = c_half_m1;
        end
      end
      RX_START: begin
        if (!w_rx_zero) begin
          w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end else if (!r_rx_sync) begin
          w_rx_state_nxt = RX_DATA;
          w_rx_cnt_nxt   = c_div_m1;
          w_rx_bit_nxt   = '0;
        end else begin
          w_rx_state_nxt = RX_IDLE;
        end
      end
      RX_DATA: begin
        if (!w_rx_zero) begin
          w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end else begin
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_cnt_nxt   = c_div_m1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          else                  w_rx_bit_nxt   = r_rx_bit + 1'b1;
        end
      end
      RX_STOP: begin
        if (!w_rx_zero) begin
          w_rx_cnt_nxt = r_rx_cnt - 1'b1;
        end else begin
          // A low stop bit is a framing error: the byte is silently dropped.
          w_rx_push      = r_rx_sync;
          w_rx_state_nxt = RX_IDLE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]  r_fifo [RX_DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic        w_empty, w_full, w_rd, w_wr, w_pop, w_push_ok, w_ovr_set;
  logic        r_ovr;

  assign w_rd      = uart_en && !uart_we;
  assign w_wr      = uart_en && uart_we;
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop     = w_rd && !uart_addr && !w_empty;
  assign w_push_ok = w_rx_push && (!w_full || w_pop);
  assign w_ovr_set = w_rx_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wp[AW-1:0]] <= r_rx_shift;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      // A new overrun in the same cycle as the clearing read must survive.
      if (w_ovr_set)              r_ovr <= 1'b1;
      else if (w_rd && uart_addr) r_ovr <= 1'b0;
    end
  end

  assign uart_overrun = r_ovr;

  // ---------------- TX ----------------
  logic [7:0]    r_hold;
  logic          r_hold_full;
  logic          w_hold_load, w_hold_take;
  tx_state_t     r_tx_state, w_tx_state_nxt;
  logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
  logic [2:0]    r_tx_bit, w_tx_bit_nxt;
  logic [7:0]    r_tx_shift, w_tx_shift_nxt;
  logic          r_txd, w_txd_nxt;
  logic          w_tx_zero;

  assign w_tx_zero   = (r_tx_cnt == '0);
  assign w_hold_load = w_wr && !uart_addr && !r_hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_shift  <= '0;
      r_txd       <= 1'b1;
    end else begin
      if (w_hold_load) begin
        r_hold      <= uart_wdata;
        r_hold_full <= 1'b1;
      end else if (w_hold_take) begin
        r_hold_full <= 1'b0;
      end
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_txd      <= w_txd_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_txd_nxt      = r_txd;
    w_hold_take    = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (r_hold_full) begin
          w_hold_take    = 1'b1;
          w_tx_shift_nxt = r_hold;
          w_txd_nxt      = 1'b0;
          w_tx_cnt_nxt   = c_div_m1;
          w_tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (!w_tx_zero) begin
          w_tx_cnt_nxt = r_tx_cnt - 1'b1;
        end else begin
          w_txd_nxt      = r_tx_shift[0];
          w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
          w_tx_bit_nxt   = '0;
          w_tx_cnt_nxt   = c_div_m1;
          w_tx_state_nxt = TX_DATA;
        end
      end
      TX_DATA: begin
        if (!w_tx_zero) begin
          w_tx_cnt_nxt = r_tx_cnt - 1'b1;
        end else begin
          w_tx_cnt_nxt = c_div_m1;
          if (r_tx_bit == 3'd7) begin
            w_txd_nxt      = 1'b1;
            w_tx_state_nxt = TX_STOP;
          end else begin
            w_txd_nxt      = r_tx_shift[0];
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_bit_nxt   = r_tx_bit + 1'b1;
          end
        end
      end
      TX_STOP: begin
        if (!w_tx_zero) begin
          w_tx_cnt_nxt = r_tx_cnt - 1'b1;
        end else if (r_hold_full) begin
          // Chain straight into the next frame with no idle gap.
          w_hold_take    = 1'b1;
          w_tx_shift_nxt = r_hold;
          w_txd_nxt      = 1'b0;
          w_tx_cnt_nxt   = c_div_m1;
          w_tx_state_nxt = TX_START;
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  assign txd = r_txd;

  // ---------------- Bus read port ----------------
  logic [31:0] r_rdata;
  logic [31:0] w_status;
  logic [31:0] w_data;

  assign w_status = {29'b0, r_ovr, !w_empty, !r_hold_full};
  assign w_data   = w_empty ? 32'b0 : {24'b0, r_fifo[r_rp[AW-1:0]]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (w_rd) r_rdata <= uart_addr ? w_status : w_data;
  end

  assign uart_rdata = r_rdata;

endmodule
`default_nettype wire
